// File: rtl/irq_pkg.sv
// Shared widths, defaults and FSM state encoding for the interrupt handshake controller.
package irq_pkg;

    localparam int unsigned NUM_IRQ_DEFAULT = 16;
    localparam int unsigned ID_W            = 4;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SERVICE,
        EOI
    } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Per-line synchronizer for an asynchronous pad input, followed by a rising-edge detector.
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic irq,
    output logic rise_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_handshake_ctrl.sv
// Edge-triggered interrupt controller: pending bits, lowest-index dispatch with a
// valid/ready vector handshake, done matching and a fixed-width end-of-interrupt pulse.
module irq_handshake_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = NUM_IRQ_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EOI_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [NUM_IRQ-1:0] eoi,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               vec_valid,
    output logic [ID_W-1:0]    vec_id,
    input  logic               vec_ready,
    input  logic               done_valid,
    input  logic [ID_W-1:0]    done_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               busy
);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] eoi_q, eoi_d;
    logic               vec_valid_q, vec_valid_d;
    logic [ID_W-1:0]    vec_id_q, vec_id_d;
    logic [ID_W-1:0]    isvc_q, isvc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] req;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] isvc_onehot;
    logic [ID_W-1:0]    low_id;

    for (genvar g = 0; g < int'(NUM_IRQ); g++) begin : g_sync
        irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rstn  (rstn),
            .irq   (irq[g]),
            .rise_c(rise[g])
        );
    end

    assign req = pending_q & ~irq_mask;

    // Lowest pending unmasked index wins dispatch.
    always_comb begin
        low_id = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                low_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        isvc_onehot = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            isvc_onehot[i] = (ID_W'(i) == isvc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            eoi_q       <= '0;
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
            isvc_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            eoi_q       <= eoi_d;
            vec_valid_q <= vec_valid_d;
            vec_id_q    <= vec_id_d;
            isvc_q      <= isvc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        eoi_d       = eoi_q;
        vec_valid_d = vec_valid_q;
        vec_id_d    = vec_id_q;
        isvc_d      = isvc_q;
        cnt_d       = cnt_q;
        pend_clr    = '0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = OFFER;
                    vec_valid_d = 1'b1;
                    vec_id_d    = low_id;
                end
            end
            OFFER: begin
                if (vec_ready) begin
                    for (int i = 0; i < int'(NUM_IRQ); i++) begin
                        pend_clr[i] = (ID_W'(i) == vec_id_q);
                    end
                    isvc_d      = vec_id_q;
                    vec_valid_d = 1'b0;
                    state_d     = SERVICE;
                end
            end
            SERVICE: begin
                if (done_valid && (done_id == isvc_q)) begin
                    eoi_d   = isvc_onehot;
                    cnt_d   = '0;
                    state_d = EOI;
                end
            end
            EOI: begin
                if (cnt_q == CNT_W'(EOI_CYCLES - 1)) begin
                    eoi_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new edge in the same cycle as the dispatch clear keeps the bit set.
        pending_d = (pending_q & ~pend_clr) | rise;
        busy_d    = (state_d != IDLE);
    end

    assign pending   = pending_q;
    assign eoi       = eoi_q;
    assign vec_valid = vec_valid_q;
    assign vec_id    = vec_id_q;
    assign busy      = busy_q;

endmodule
